ppu_bus_arbiter: RTL and testbench

PPU_BUS_ARBITER -- requirements
Module: ppu_bus_arbiter

---
 rtl/ppu_bus_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_ppu_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ppu_bus_arbiter
// Purpose  : Arbitrates the PPU memory-map bus between the render fetch port
//            and the CPU PPUDATA port. Render has priority, and a starvation
//            counter forces a CPU grant after STARVE_LIMIT render grants. Each
//            access holds one active-low enable for ACCESS_CYCLES cycles, then
//            spends one COMPLETE cycle that pulses valid and can re-arbitrate.
// Revision : 1.0 - initial release
// ============================================================================
module ppu_bus_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  input  logic        i_req_render,
  input  logic [13:0] i_address_render,
  output logic        o_ack_render,
  output logic        o_valid_render,
  output logic [7:0]  o_data_render,

  input  logic        i_req_cpu,
  input  logic        i_rw_cpu,
  input  logic [13:0] i_address_cpu,
  input  logic [7:0]  i_data_cpu,
  output logic        o_ack_cpu,
  output logic        o_valid_cpu,
  output logic [7:0]  o_data_cpu,

  output logic [13:0] o_address_ppu,
  output logic        o_rd_en_ppu_n,
  output logic        o_wr_en_ppu_n,
  output logic [7:0]  o_data_ppu,
  input  logic [7:0]  i_data_ppu
);

  // Index of the final ACCESS cycle and the starvation threshold, sized to
  // the counters that compare against them.
  localparam logic [1:0] c_last_cycle  = 2'(ACCESS_CYCLES - 1);
  localparam logic [3:0] c_starve_max  = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [1:0]  r_cycle;        // cycles already spent in ACCESS
  logic [3:0]  r_starve;       // render grants while the CPU was waiting
  logic        r_owner_cpu;    // current/last access belongs to the CPU port
  logic        r_is_read;      // current/last access is a read
  logic [13:0] r_address;
  logic [7:0]  r_wdata;
  logic [7:0]  r_data_render;
  logic [7:0]  r_data_cpu;

  logic        w_arb;
  logic        w_starved;
  logic        w_grant_cpu;
  logic        w_grant_render;
  logic        w_grant;
  logic        w_last;
  logic        w_in_access;
  logic        w_in_complete;

  // Arbitration: render wins unless the CPU has waited STARVE_LIMIT grants.
  // No grant is issued while reset is held, so the first grant after release
  // lands on the first rising edge with reset high.
  always_comb begin
    w_in_access    = (r_state == ST_ACCESS);
    w_in_complete  = (r_state == ST_COMPLETE);
    w_arb          = i_reset_n & ~w_in_access;
    w_starved      = (r_starve == c_starve_max);
    w_grant_cpu    = w_arb & i_req_cpu & (~i_req_render | w_starved);
    w_grant_render = w_arb & i_req_render & ~w_grant_cpu;
    w_grant        = w_grant_cpu | w_grant_render;
    w_last         = w_in_access & (r_cycle == c_last_cycle);
  end

  // Next-state logic for the IDLE / ACCESS / COMPLETE sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (w_last) begin
          w_state_next = ST_COMPLETE;
        end
      end
      ST_COMPLETE: begin
        if (w_grant) begin
          w_state_next = ST_ACCESS;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any in-flight access.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ACCESS cycle counter: restarts on every grant, advances until the last cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycle <= 2'd0;
    end else if (w_grant) begin
      r_cycle <= 2'd0;
    end else if (w_in_access && !w_last) begin
      r_cycle <= r_cycle + 2'd1;
    end
  end

  // Starvation counter: counts render grants while the CPU is asking, clears
  // when the CPU is served or stops asking, and never passes the limit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_starve <= 4'd0;
    end else if (!i_req_cpu || w_grant_cpu) begin
      r_starve <= 4'd0;
    end else if (w_grant_render && !w_starved) begin
      r_starve <= r_starve + 4'd1;
    end
  end

  // Transfer latch: captured on the grant edge so requester changes during
  // ACCESS cannot disturb the bus. Write data only moves on CPU grants, so
  // the memory-map data bus keeps its last value across render reads.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner_cpu <= 1'b0;
      r_is_read   <= 1'b1;
      r_address   <= 14'd0;
      r_wdata     <= 8'd0;
    end else if (w_grant) begin
      r_owner_cpu <= w_grant_cpu;
      r_is_read   <= w_grant_cpu ? i_rw_cpu : 1'b1;
      r_address   <= w_grant_cpu ? i_address_cpu : i_address_render;
      if (w_grant_cpu) begin
        r_wdata <= i_data_cpu;
      end
    end
  end

  // Read data capture on the last ACCESS cycle into the owner's register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data_render <= 8'd0;
      r_data_cpu    <= 8'd0;
    end else if (w_last && r_is_read) begin
      if (r_owner_cpu) begin
        r_data_cpu <= i_data_ppu;
      end else begin
        r_data_render <= i_data_ppu;
      end
    end
  end

  // Output decode: exactly one enable low in ACCESS, valid only in COMPLETE.
  always_comb begin
    o_ack_render   = w_grant_render;
    o_ack_cpu      = w_grant_cpu;
    o_rd_en_ppu_n  = ~(w_in_access & r_is_read);
    o_wr_en_ppu_n  = ~(w_in_access & ~r_is_read);
    o_valid_render = w_in_complete & ~r_owner_cpu;
    o_valid_cpu    = w_in_complete & r_owner_cpu;
    o_address_ppu  = r_address;
    o_data_ppu     = r_wdata;
    o_data_render  = r_data_render;
    o_data_cpu     = r_data_cpu;
  end

endmodule
`default_nettype wire

// File: tb/tb_ppu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppu_bus_arbiter
// Purpose  : Directed and randomized checks of ppu_bus_arbiter. Instance 0
//            uses ACCESS_CYCLES=2/STARVE_LIMIT=4, instance 1 uses 1/2.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppu_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_r   [2];
  logic        req_c   [2];
  logic        rw_c    [2];
  logic [13:0] addr_r  [2];
  logic [13:0] addr_c  [2];
  logic [7:0]  dcpu    [2];
  logic [7:0]  dppu_in [2];
  logic        ack_r   [2];
  logic        ack_c   [2];
  logic        val_r   [2];
  logic        val_c   [2];
  logic        rd_n    [2];
  logic        wr_n    [2];
  logic [7:0]  data_r  [2];
  logic [7:0]  data_c  [2];
  logic [7:0]  dppu_out[2];
  logic [13:0] addr_p  [2];

  ppu_bus_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_render(req_r[0]), .i_address_render(addr_r[0]),
    .o_ack_render(ack_r[0]), .o_valid_render(val_r[0]), .o_data_render(data_r[0]),
    .i_req_cpu(req_c[0]), .i_rw_cpu(rw_c[0]), .i_address_cpu(addr_c[0]),
    .i_data_cpu(dcpu[0]), .o_ack_cpu(ack_c[0]), .o_valid_cpu(val_c[0]),
    .o_data_cpu(data_c[0]), .o_address_ppu(addr_p[0]), .o_rd_en_ppu_n(rd_n[0]),
    .o_wr_en_ppu_n(wr_n[0]), .o_data_ppu(dppu_out[0]), .i_data_ppu(dppu_in[0])
  );

  ppu_bus_arbiter #(.ACCESS_CYCLES(1), .STARVE_LIMIT(2)) dut1 (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_render(req_r[1]), .i_address_render(addr_r[1]),
    .o_ack_render(ack_r[1]), .o_valid_render(val_r[1]), .o_data_render(data_r[1]),
    .i_req_cpu(req_c[1]), .i_rw_cpu(rw_c[1]), .i_address_cpu(addr_c[1]),
    .i_data_cpu(dcpu[1]), .o_ack_cpu(ack_c[1]), .o_valid_cpu(val_c[1]),
    .o_data_cpu(data_c[1]), .o_address_ppu(addr_p[1]), .o_rd_en_ppu_n(rd_n[1]),
    .o_wr_en_ppu_n(wr_n[1]), .o_data_ppu(dppu_out[1]), .i_data_ppu(dppu_in[1])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: each access is a grant followed by
  // ACCESS_CYCLES bus cycles and one completion cycle (age counts from grant).
  bit          m_active [2];
  int          m_age    [2];
  int          m_starve [2];
  bit          m_own_cpu[2];
  bit          m_read   [2];
  logic [13:0] m_addr   [2];
  logic [7:0]  m_wdata  [2];
  logic [7:0]  m_dr     [2];
  logic [7:0]  m_dc     [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_active[k] = 1'b0; m_age[k] = 0; m_starve[k] = 0;
      m_own_cpu[k] = 1'b0; m_read[k] = 1'b1;
      m_addr[k] = '0; m_wdata[k] = '0; m_dr[k] = '0; m_dc[k] = '0;
    end
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) begin
      req_r[k] = 1'b0; req_c[k] = 1'b0; rw_c[k] = 1'b0;
      addr_r[k] = '0; addr_c[k] = '0; dcpu[k] = '0; dppu_in[k] = '0;
    end
  endtask

  task automatic check_reset_vals(input int k, input string tag);
    chk($sformatf("%s_ctl%0d", tag, k),
        {26'd0, ack_r[k], ack_c[k], val_r[k], val_c[k], rd_n[k], wr_n[k]},
        {26'd0, 6'b000011});
    chk($sformatf("%s_data%0d", tag, k),
        {addr_p[k], 2'b00, dppu_out[k], data_r[k], data_c[k]}, 32'd0);
  endtask

  task automatic model_cycle(input int k);
    int ac, sl;
    bit in_acc, in_cmp, e_ack_c, e_ack_r;
    ac = (k == 0) ? 2 : 1;
    sl = (k == 0) ? 4 : 2;
    in_acc  = m_active[k] && (m_age[k] >= 1) && (m_age[k] <= ac);
    in_cmp  = m_active[k] && (m_age[k] == ac + 1);
    e_ack_c = !in_acc && req_c[k] && (!req_r[k] || (m_starve[k] == sl));
    e_ack_r = !in_acc && req_r[k] && !e_ack_c;
    chk($sformatf("rnd_ctl%0d", k),
        {26'd0, ack_r[k], ack_c[k], val_r[k], val_c[k], rd_n[k], wr_n[k]},
        {26'd0, e_ack_r, e_ack_c, in_cmp && !m_own_cpu[k], in_cmp && m_own_cpu[k],
         !(in_acc && m_read[k]), !(in_acc && !m_read[k])});
    chk($sformatf("rnd_data_render%0d", k), {24'd0, data_r[k]}, {24'd0, m_dr[k]});
    chk($sformatf("rnd_data_cpu%0d", k), {24'd0, data_c[k]}, {24'd0, m_dc[k]});
    chk($sformatf("rnd_addr%0d", k), {18'd0, addr_p[k]}, {18'd0, m_addr[k]});
    chk($sformatf("rnd_dppu%0d", k), {24'd0, dppu_out[k]}, {24'd0, m_wdata[k]});
    // advance one clock
    if (in_acc && (m_age[k] == ac) && m_read[k]) begin
      if (m_own_cpu[k]) m_dc[k] = dppu_in[k];
      else              m_dr[k] = dppu_in[k];
    end
    if (!req_c[k] || e_ack_c) m_starve[k] = 0;
    else if (e_ack_r && (m_starve[k] < sl)) m_starve[k] = m_starve[k] + 1;
    if (e_ack_c || e_ack_r) begin
      m_active[k]  = 1'b1;
      m_age[k]     = 1;
      m_own_cpu[k] = e_ack_c;
      m_read[k]    = e_ack_c ? rw_c[k] : 1'b1;
      m_addr[k]    = e_ack_c ? addr_c[k] : addr_r[k];
      if (e_ack_c) m_wdata[k] = dcpu[k];
    end else if (in_cmp) begin
      m_active[k] = 1'b0;
    end else if (m_active[k]) begin
      m_age[k] = m_age[k] + 1;
    end
  endtask

  task automatic rand_inputs(input int k, input bit burst);
    req_r[k]   = burst ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 50);
    req_c[k]   = burst ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 40);
    rw_c[k]    = $urandom_range(0, 1) == 1;
    addr_r[k]  = 14'($urandom);
    addr_c[k]  = 14'($urandom);
    dcpu[k]    = 8'($urandom);
    dppu_in[k] = 8'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) check_reset_vals(k, "rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Render read 0x2005 returning 0xA7: ack, two read cycles, valid.
    req_r[0] = 1'b1; addr_r[0] = 14'h2005; dppu_in[0] = 8'h00;
    #1 chk("d1_ack", ack_r[0], 1);
    @(negedge clk); req_r[0] = 1'b0;
    #1 chk("d1_rd_c1", {rd_n[0], wr_n[0]}, 2'b01);
    chk("d1_addr", addr_p[0], 14'h2005);
    @(negedge clk); dppu_in[0] = 8'hA7;
    #1 chk("d1_rd_c2", rd_n[0], 0);
    @(negedge clk); dppu_in[0] = 8'h55;
    #1 chk("d1_rd_c3", {rd_n[0], wr_n[0]}, 2'b11);
    chk("d1_valid", val_r[0], 1);
    chk("d1_data", data_r[0], 8'hA7);
    @(negedge clk);
    #1 chk("d1_pulse", val_r[0], 0);
    chk("d1_hold", data_r[0], 8'hA7);
    @(negedge clk);

    // CPU write 0x3F00 <- 0x1C.
    req_c[0] = 1'b1; rw_c[0] = 1'b0; addr_c[0] = 14'h3F00; dcpu[0] = 8'h1C;
    #1 chk("d2_ack", {ack_r[0], ack_c[0]}, 2'b01);
    @(negedge clk); req_c[0] = 1'b0; dcpu[0] = 8'hFF;
    #1 chk("d2_wr_c1", {rd_n[0], wr_n[0]}, 2'b10);
    chk("d2_addr", addr_p[0], 14'h3F00);
    chk("d2_dppu", dppu_out[0], 8'h1C);
    @(negedge clk);
    #1 chk("d2_wr_c2", {rd_n[0], wr_n[0]}, 2'b10);
    chk("d2_dppu_hold", dppu_out[0], 8'h1C);
    @(negedge clk);
    #1 chk("d2_wr_c3", {rd_n[0], wr_n[0]}, 2'b11);
    chk("d2_valid", val_c[0], 1);
    chk("d2_data_cpu", data_c[0], 8'h00);
    @(negedge clk);
    #1 chk("d2_pulse", val_c[0], 0);
    @(negedge clk);

    // Simultaneous single requests: render first, CPU in the COMPLETE cycle.
    req_r[0] = 1'b1; req_c[0] = 1'b1; rw_c[0] = 1'b1;
    addr_r[0] = 14'h0123; addr_c[0] = 14'h2345;
    #1 chk("d3_ack0", {ack_r[0], ack_c[0]}, 2'b10);
    @(negedge clk); req_r[0] = 1'b0;
    #1 chk("d3_noack1", ack_c[0], 0);
    @(negedge clk);
    #1 chk("d3_noack2", ack_c[0], 0);
    @(negedge clk);
    #1 chk("d3_cmp", {val_r[0], ack_c[0]}, 2'b11);
    @(negedge clk); req_c[0] = 1'b0;
    #1 chk("d3_cpu_rd", rd_n[0], 0);
    chk("d3_addr", addr_p[0], 14'h2345);
    @(negedge clk); dppu_in[0] = 8'h3C;
    @(negedge clk); dppu_in[0] = 8'h00;
    #1 chk("d3_valid", val_c[0], 1);
    chk("d3_data_cpu", data_c[0], 8'h3C);
    @(negedge clk);

    // Both held: R,R,R,R,C repeating with one grant every three cycles.
    req_r[0] = 1'b1; req_c[0] = 1'b1; rw_c[0] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      int g;
      logic [1:0] e;
      g = i / 3;
      e = (i % 3 != 0) ? 2'b00 : ((g % 5 == 4) ? 2'b01 : 2'b10);
      #1 chk($sformatf("d4_grant%0d", i), {ack_r[0], ack_c[0]}, e);
      @(negedge clk);
    end
    req_r[0] = 1'b0; req_c[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Reset in the second ACCESS cycle aborts the read.
    req_r[0] = 1'b1; addr_r[0] = 14'h1234;
    #1 chk("d5_ack", ack_r[0], 1);
    @(negedge clk);
    @(negedge clk);
    #1 chk("d5_rd", rd_n[0], 0);
    #1 rst_n = 1'b0;
    #1 chk("d5_abort", {rd_n[0], wr_n[0], val_r[0]}, 3'b110);
    @(negedge clk);
    #1 chk("d5_inrst", {val_r[0], ack_r[0], rd_n[0]}, 3'b001);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("d5_reack", ack_r[0], 1);
    @(negedge clk); req_r[0] = 1'b0;
    #1 chk("d5_rd_again", rd_n[0], 0);
    @(negedge clk);
    @(negedge clk);
    #1 chk("d5_valid", val_r[0], 1);
    @(negedge clk);

    // ACCESS_CYCLES=1: back-to-back render reads, one valid every 2 cycles.
    req_r[1] = 1'b1; addr_r[1] = 14'h0AA0;
    for (int i = 0; i < 12; i++) begin
      dppu_in[1] = 8'(i + 16);
      #1 chk($sformatf("d6_ack%0d", i), ack_r[1], (i % 2 == 0));
      chk($sformatf("d6_rd%0d", i), rd_n[1], (i % 2 == 0));
      chk($sformatf("d6_val%0d", i), val_r[1], (i >= 2 && i % 2 == 0));
      chk($sformatf("d6_excl%0d", i), rd_n[1] | wr_n[1], 1);
      if (i >= 2 && i % 2 == 0) chk($sformatf("d6_data%0d", i), data_r[1], 8'(i + 15));
      @(negedge clk);
    end
    req_r[1] = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized traffic on both instances against the reference model.
    rst_n = 1'b0;
    idle_all();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int k = 0; k < 2; k++) rand_inputs(k, ((cyc / 40) % 2) == 1);
      #1;
      for (int k = 0; k < 2; k++) model_cycle(k);
      if (cyc == 300 || cyc == 451) begin
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) check_reset_vals(k, "rnd_rst");
        @(negedge clk);
        idle_all();
        #1;
        for (int k = 0; k < 2; k++) check_reset_vals(k, "rnd_rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
